pwm_cfg_wbm: RTL and testbench

- Wishbone initiator that loads the PWM block's 18-bit period/compare registers over its 8-bit, 2-bit-address, write-only slave port.
- Accepts one command (target register and 18-bit value) on a valid/ready handshake.
- Serialises the command into four byte writes and reports completion or error on a one-cycle response strobe.
- Sits between the host command decoder (UART/SPI front end) and the pwm slave.

---
 rtl/pwm_pkg.sv | 44 ++++
 rtl/wb_ack_timer.sv | 36 +++
 rtl/pwm_cfg_wbm.sv | 155 +++++++++++++++
 tb/tb_pwm_cfg_wbm.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, state encoding and beat-map helper for the PWM configuration
// Wishbone initiator.
package pwm_pkg;

  localparam int PWM_REG_W = 18;
  localparam int WB_ADR_W  = 2;
  localparam int WB_DAT_W  = 8;

  localparam logic [2:0] TGT_PRD   = 3'd0;
  localparam logic [2:0] TGT_CMPH0 = 3'd1;
  localparam logic [2:0] TGT_CMPL0 = 3'd2;
  localparam logic [2:0] TGT_CMPH1 = 3'd3;
  localparam logic [2:0] TGT_CMPL1 = 3'd4;
  localparam int         TGT_NUM   = 5;

  localparam logic [WB_ADR_W-1:0] ADR_B0     = 2'd0;
  localparam logic [WB_ADR_W-1:0] ADR_B1     = 2'd1;
  localparam logic [WB_ADR_W-1:0] ADR_B2     = 2'd2;
  localparam logic [WB_ADR_W-1:0] ADR_COMMIT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_GAP  = 2'd2,
    ST_RESP = 2'd3
  } wbm_state_e;

  // The slave latches the staged bytes into the target register on the commit beat.
  function automatic logic [WB_DAT_W-1:0] beat_byte(
    input logic [WB_ADR_W-1:0]  beat,
    input logic [2:0]           tgt,
    input logic [PWM_REG_W-1:0] val
  );
    logic [WB_DAT_W-1:0] b;
    case (beat)
      ADR_B0:  b = val[7:0];
      ADR_B1:  b = val[15:8];
      ADR_B2:  b = {6'b0, val[17:16]};
      default: b = {5'b0, tgt};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Wait-state counter for a bus initiator: counts enabled cycles and flags
// expiry once LIMIT-1 cycles have elapsed; clear has priority.
module wb_ack_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/pwm_cfg_wbm.sv
// Wishbone initiator that writes an 18-bit PWM register as four byte beats
// and reports completion/error on a one-cycle response strobe.
//   state | meaning
//   IDLE  | ready for a command
//   BEAT  | strobe high for the current byte, waiting for ack or timeout
//   GAP   | one idle cycle inside the bus cycle, advance to next byte
//   RESP  | one-cycle response pulse
module pwm_cfg_wbm
  import pwm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15,
  parameter bit NO_ACK      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_target,
  input  logic [PWM_REG_W-1:0] cmd_value,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [WB_ADR_W-1:0]  wb_adr_o,
  output logic [WB_DAT_W-1:0]  wb_dat_o,
  input  logic                 wb_ack_i
);

  wbm_state_e           state_q, state_d;
  logic [WB_ADR_W-1:0]  beat_q, beat_d;
  logic [2:0]           tgt_q, tgt_d;
  logic [PWM_REG_W-1:0] val_q, val_d;
  logic                 err_q, err_d;

  logic                 ready_q, ready_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic [WB_ADR_W-1:0]  adr_q, adr_d;
  logic [WB_DAT_W-1:0]  dat_q, dat_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;

  logic ack_eff;
  logic tmr_en;
  logic tmr_expired;

  assign ack_eff = NO_ACK ? 1'b1 : wb_ack_i;
  assign tmr_en  = (state_q == ST_BEAT) && !ack_eff;

  wb_ack_timer #(
    .LIMIT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!tmr_en),
    .en_i     (tmr_en),
    .expired_o(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      tgt_q       <= '0;
      val_q       <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      tgt_q       <= tgt_d;
      val_q       <= val_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Ack is only looked at in BEAT, so acks during GAP/IDLE/RESP are ignored.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tgt_d   = tgt_q;
    val_d   = val_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ready_q && cmd_valid) begin
          tgt_d  = cmd_target;
          val_d  = cmd_value;
          beat_d = ADR_B0;
          if (int'(cmd_target) < TGT_NUM) begin
            state_d = ST_BEAT;
            err_d   = 1'b0;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end
        end
      end
      ST_BEAT: begin
        if (ack_eff) begin
          if (beat_q == ADR_COMMIT) begin
            state_d = ST_RESP;
            err_d   = 1'b0;
          end else begin
            state_d = ST_GAP;
          end
        end else if (tmr_expired) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end
      end
      ST_GAP: begin
        beat_d  = beat_q + 1'b1;
        state_d = ST_BEAT;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the bus is glitch-free.
  always_comb begin
    ready_d     = (state_d == ST_IDLE);
    cyc_d       = (state_d == ST_BEAT) || (state_d == ST_GAP);
    stb_d       = (state_d == ST_BEAT);
    adr_d       = stb_d ? beat_d : '0;
    dat_d       = stb_d ? beat_byte(beat_d, tgt_d, val_d) : '0;
    rsp_valid_d = (state_d == ST_RESP);
    rsp_err_d   = rsp_valid_d && err_d;
  end

  assign cmd_ready = ready_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = stb_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_pwm_cfg_wbm.sv
// Self-checking bench for pwm_cfg_wbm: an acking DUT driven from a vector table
// with a write/response scoreboard, plus a NO_ACK instance for back-to-back commands.
module tb_pwm_cfg_wbm;

  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        va, rdya, rspv_a, rspe_a, cyc_a, stb_a, we_a, ack_a;
  logic [2:0]  tgta;
  logic [17:0] vala;
  logic [1:0]  adr_a;
  logic [7:0]  dat_a;

  logic        vb, rdyb, rspv_b, rspe_b, cyc_b, stb_b, we_b;
  logic [2:0]  tgtb;
  logic [17:0] valb;
  logic [1:0]  adr_b;
  logic [7:0]  dat_b;

  pwm_cfg_wbm #(.ACK_TIMEOUT(TMO), .NO_ACK(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(va), .cmd_ready(rdya), .cmd_target(tgta), .cmd_value(vala),
    .rsp_valid(rspv_a), .rsp_err(rspe_a),
    .wb_cyc_o(cyc_a), .wb_stb_o(stb_a), .wb_we_o(we_a),
    .wb_adr_o(adr_a), .wb_dat_o(dat_a), .wb_ack_i(ack_a)
  );

  pwm_cfg_wbm #(.ACK_TIMEOUT(TMO), .NO_ACK(1'b1)) u_dut_na (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(vb), .cmd_ready(rdyb), .cmd_target(tgtb), .cmd_value(valb),
    .rsp_valid(rspv_b), .rsp_err(rspe_b),
    .wb_cyc_o(cyc_b), .wb_stb_o(stb_b), .wb_we_o(we_b),
    .wb_adr_o(adr_b), .wb_dat_o(dat_b), .wb_ack_i(1'b0)
  );

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, edge_cnt + 1);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int b, input logic [2:0] t, input logic [17:0] v);
    case (b)
      0:       return v[7:0];
      1:       return v[15:8];
      2:       return {6'b0, v[17:16]};
      default: return {5'b0, t};
    endcase
  endfunction

  // Acking slave for u_dut: per-byte wait states, optional ack outside strobe.
  logic [3:0][7:0] cur_dl;
  bit              spur;
  int              wcnt;
  initial begin
    ack_a = 1'b0;
    wcnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stb_a) begin
        ack_a = (wcnt >= int'(cur_dl[adr_a]));
        wcnt++;
      end else begin
        wcnt  = 0;
        ack_a = spur && cyc_a;
      end
    end
  end

  typedef struct {
    logic [1:0] adr;
    logic [7:0] dat;
  } wr_t;

  wr_t  exp_wr_q[$];
  bit   exp_rsp_q[$];
  int   stb_cnt[4];
  int   rsp_cnt = 0;
  wr_t  e_wr;
  bit   e_err;
  logic p_stb = 1'b0, p_ack = 1'b0;
  logic [1:0] p_adr = '0;
  logic [7:0] p_dat = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (stb_a) begin
        stb_cnt[adr_a]++;
        chk("we_cyc_with_stb", {30'b0, we_a, cyc_a}, 32'h3);
        if (p_stb && !p_ack) begin
          chk("adr_stable", {30'b0, adr_a}, {30'b0, p_adr});
          chk("dat_stable", {24'b0, dat_a}, {24'b0, p_dat});
        end
        if (ack_a) begin
          chk("write_expected", int'(exp_wr_q.size() > 0), 1);
          if (exp_wr_q.size() > 0) begin
            e_wr = exp_wr_q.pop_front();
            chk("wr_adr", {30'b0, adr_a}, {30'b0, e_wr.adr});
            chk("wr_dat", {24'b0, dat_a}, {24'b0, e_wr.dat});
          end
        end
      end else if (we_a) begin
        chk("we_without_stb", {31'b0, we_a}, 0);
      end
      if (rspv_a) begin
        rsp_cnt++;
        chk("rsp_expected", int'(exp_rsp_q.size() > 0), 1);
        if (exp_rsp_q.size() > 0) begin
          e_err = exp_rsp_q.pop_front();
          chk("rsp_err", {31'b0, rspe_a}, {31'b0, e_err});
        end
      end else if (rspe_a) begin
        chk("err_without_valid", {31'b0, rspe_a}, 0);
      end
      p_stb = stb_a;
      p_ack = ack_a;
      p_adr = adr_a;
      p_dat = dat_a;
    end
  end

  // Log of the NO_ACK instance's strobes and responses.
  typedef struct {
    int         cyc;
    logic [1:0] adr;
    logic [7:0] dat;
  } bl_t;
  bl_t  blog[$];
  int   brsp_cyc[$];
  logic brsp_err[$];
  initial begin
    forever begin
      @(negedge clk);
      if (stb_b) blog.push_back('{edge_cnt + 1, adr_b, dat_b});
      if (rspv_b) begin
        brsp_cyc.push_back(edge_cnt + 1);
        brsp_err.push_back(rspe_b);
      end
    end
  end

  task automatic send_a(input logic [2:0] t, input logic [17:0] v, output int n);
    int g = 0;
    @(negedge clk);
    tgta = t;
    vala = v;
    va   = 1'b1;
    while (!rdya && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("accept_seen", {31'b0, rdya}, 1);
    n = edge_cnt + 1;
    @(negedge clk);
    va = 1'b0;
  endtask

  task automatic wait_rsp(output int rc);
    int g = 0;
    while (!rspv_a && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("rsp_seen", {31'b0, rspv_a}, 1);
    rc = edge_cnt + 1;
    chk("ready_low_at_rsp", {31'b0, rdya}, 0);
    @(negedge clk);
    chk("ready_after_rsp", {31'b0, rdya}, 1);
  endtask

  typedef struct {
    logic [2:0]      tgt;
    logic [17:0]     val;
    logic [3:0][7:0] dl;
    bit              spur;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int  n, rc, off, total;
    int  exp_cnt[4];
    bit  err, done;
    cur_dl = v.dl;
    spur   = v.spur;
    for (int b = 0; b < 4; b++) begin
      stb_cnt[b] = 0;
      exp_cnt[b] = 0;
    end
    err = 1'b0; done = 1'b0; total = 0; off = 1;
    if (int'(v.tgt) >= 5) begin
      err = 1'b1;
    end else begin
      for (int b = 0; b < 4 && !done; b++) begin
        if (int'(v.dl[b]) >= TMO) begin
          exp_cnt[b] = TMO;
          total += TMO;
          off  = total + b + 1;
          err  = 1'b1;
          done = 1'b1;
        end else begin
          exp_cnt[b] = int'(v.dl[b]) + 1;
          total += exp_cnt[b];
          exp_wr_q.push_back('{2'(b), exp_byte(b, v.tgt, v.val)});
          if (b == 3) off = total + 4;
        end
      end
    end
    exp_rsp_q.push_back(err);
    send_a(v.tgt, v.val, n);
    wait_rsp(rc);
    chk("rsp_cycle", rc, n + off);
    for (int b = 0; b < 4; b++)
      chk($sformatf("stb_cycles_adr%0d", b), stb_cnt[b], exp_cnt[b]);
    chk("wr_queue_drained", exp_wr_q.size(), 0);
  endtask

  localparam int NV = 13;
  vec_t vec[NV];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, n2, g, rc0, idx, nk;
    logic [2:0]  tk;
    logic [17:0] vk;

    vec[0]  = '{3'd0, 18'h2ABCD, {8'd0,   8'd0,   8'd0, 8'd0},   1'b0};
    vec[1]  = '{3'd1, 18'h3FFFF, {8'd0,   8'd0,   8'd0, 8'd0},   1'b0};
    vec[2]  = '{3'd2, 18'h00005, {8'd0,   8'd0,   8'd3, 8'd0},   1'b0};
    vec[3]  = '{3'd3, 18'h10001, {8'd0,   8'd2,   8'd0, 8'd1},   1'b1};
    vec[4]  = '{3'd4, 18'h00000, {8'd5,   8'd0,   8'd0, 8'd0},   1'b0};
    vec[5]  = '{3'd0, 18'h2ABCD, {8'd0,   8'd0,   8'd0, 8'd0},   1'b1};
    vec[6]  = '{3'd5, 18'h12345, {8'd0,   8'd0,   8'd0, 8'd0},   1'b0};
    vec[7]  = '{3'd6, 18'h0ABCD, {8'd0,   8'd0,   8'd0, 8'd0},   1'b0};
    vec[8]  = '{3'd7, 18'h3FFFF, {8'd0,   8'd0,   8'd0, 8'd0},   1'b0};
    vec[9]  = '{3'd2, 18'h0F0F0, {8'd0,   8'd255, 8'd0, 8'd0},   1'b0};
    vec[10] = '{3'd1, 18'h00001, {8'd0,   8'd0,   8'd0, 8'd255}, 1'b0};
    vec[11] = '{3'd3, 18'h2AAAA, {8'd255, 8'd0,   8'd0, 8'd0},   1'b0};
    vec[12] = '{3'd4, 18'h1FFFF, {8'd0,   8'd0,   8'd13, 8'd0},  1'b0};

    rst_n = 1'b0;
    va = 1'b0; tgta = '0; vala = '0;
    vb = 1'b0; tgtb = '0; valb = '0;
    cur_dl = '0; spur = 1'b0;
    for (int b = 0; b < 4; b++) stb_cnt[b] = 0;

    repeat (3) @(negedge clk);
    chk("reset_outputs_a", {17'b0, cyc_a, stb_a, we_a, adr_a, dat_a, rdya, rspv_a, rspe_a}, 0);
    chk("reset_outputs_b", {17'b0, cyc_b, stb_b, we_b, adr_b, dat_b, rdyb, rspv_b, rspe_b}, 0);
    rst_n = 1'b1;
    chk("ready_low_before_edge", {31'b0, rdya}, 0);
    @(negedge clk);
    chk("ready_after_reset_a", {31'b0, rdya}, 1);
    chk("ready_after_reset_b", {31'b0, rdyb}, 1);

    for (int i = 0; i < NV; i++) run_vec(vec[i]);

    // Reset while beat 1 is on the bus: bus drops, no response.
    cur_dl = '0;
    spur   = 1'b0;
    exp_wr_q.push_back('{2'd0, 8'h34});
    exp_wr_q.push_back('{2'd1, 8'h12});
    send_a(3'd1, 18'h01234, n1);
    g = 0;
    while (!(stb_a && adr_a == 2'd1) && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("beat1_reached", {31'b0, stb_a}, 1);
    rc0   = rsp_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("bus_dropped_on_reset", {29'b0, cyc_a, stb_a, we_a}, 0);
    chk("ready_low_in_reset", {31'b0, rdya}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {31'b0, rdya}, 1);
    repeat (3) @(negedge clk);
    chk("no_rsp_after_reset", rsp_cnt, rc0);
    chk("reset_wr_queue_drained", exp_wr_q.size(), 0);
    run_vec(vec[1]);

    // NO_ACK instance: two back-to-back commands.
    @(negedge clk);
    tgtb = 3'd3;
    valb = 18'h1C3A5;
    vb   = 1'b1;
    g = 0;
    while (!rdyb && g < 100) begin
      @(negedge clk);
      g++;
    end
    n1 = edge_cnt + 1;
    @(negedge clk);
    tgtb = 3'd4;
    valb = 18'h2005A;
    g = 0;
    while (!rdyb && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("b_accept2_seen", {31'b0, rdyb}, 1);
    n2 = edge_cnt + 1;
    @(negedge clk);
    vb = 1'b0;
    repeat (12) @(negedge clk);

    chk("b_write_count", blog.size(), 8);
    for (int k = 0; k < 2; k++) begin
      nk = (k == 0) ? n1 : n2;
      tk = (k == 0) ? 3'd3 : 3'd4;
      vk = (k == 0) ? 18'h1C3A5 : 18'h2005A;
      for (int b = 0; b < 4; b++) begin
        idx = k * 4 + b;
        if (idx < blog.size()) begin
          chk($sformatf("b_stb_cycle_%0d", idx), blog[idx].cyc, nk + 1 + 2 * b);
          chk($sformatf("b_adr_%0d", idx), {30'b0, blog[idx].adr}, b);
          chk($sformatf("b_dat_%0d", idx), {24'b0, blog[idx].dat}, {24'b0, exp_byte(b, tk, vk)});
        end
      end
    end
    chk("b_rsp_count", brsp_cyc.size(), 2);
    if (brsp_cyc.size() >= 2) begin
      chk("b_rsp0_cycle", brsp_cyc[0], n1 + 8);
      chk("b_rsp1_cycle", brsp_cyc[1], n2 + 8);
      chk("b_rsp0_err", {31'b0, brsp_err[0]}, 0);
      chk("b_rsp1_err", {31'b0, brsp_err[1]}, 0);
      chk("b_back_to_back", n2, brsp_cyc[0] + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
